uno_seq: RTL

- Parametrised, handshaked successor of the unified nonlinear PE.
- Executes one of four ops per transaction, all on a single shared signed multiplier:
  - MAC;
  - division y/x;
  - base-2 exponent 2^x;
  - base-2 logarithm log2(x).
- Nonlinear ops use range reduction, then a programmable TERMS-coefficient Horner polynomial, then a final scale step.
- Sits in the PE array behind a valid/ready operand stream. Coefficients are loaded at runtime through a write port.

---
 rtl/uno_seq.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/uno_seq.sv
// uno_seq: handshaked MAC / division / exp2 / log2 processing element built around one shared signed multiplier.
// Optional macro UNO_SEQ_ROUND_EN: round half up on every >>> FW step of POLY and of the div SCALE.
module uno_seq #(
    parameter int DW    = 12,
    parameter int FW    = 8,
    parameter int TERMS = 4,
    parameter int AW    = 2*DW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               op,
    input  logic signed [DW-1:0]     x,
    input  logic signed [DW-1:0]     y,
    input  logic signed [AW-1:0]     z,
    input  logic                     acc_en,
    input  logic                     coef_we,
    input  logic [1:0]               coef_op,
    input  logic [$clog2(TERMS)-1:0] coef_idx,
    input  logic signed [DW-1:0]     coef_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [AW-1:0]     out_data,
    output logic                     out_err
);
    localparam int IW  = $clog2(TERMS);
    localparam int SW0 = $clog2(DW) + 2;
    localparam int SW  = (SW0 > DW-FW+1) ? SW0 : DW-FW+1;

    localparam logic [1:0] OP_MAC = 2'b00;
    localparam logic [1:0] OP_DIV = 2'b01;
    localparam logic [1:0] OP_EXP = 2'b10;

    localparam logic signed [AW-1:0] MAX_V = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_V = {1'b1, {(AW-1){1'b0}}};

`ifdef UNO_SEQ_ROUND_EN
    localparam logic signed [2*AW-1:0] RND = (2*AW)'(1) <<< (FW-1);
`else
    localparam logic signed [2*AW-1:0] RND = '0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_NORM, S_POLY, S_SCALE, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic signed [DW-1:0]  x_q, x_d, y_q, y_d;
    logic signed [AW-1:0]  acc_q, acc_d, accReg_q, accReg_d;
    logic signed [AW-1:0]  v_q, v_d, out_q, out_d;
    logic signed [SW-1:0]  e_q, e_d;
    logic                  err_q, err_d;
    logic [IW-1:0]         k_q, k_d;

    // Banks 0..2 hold the div, exp2 and log2 coefficient sets
    logic signed [DW-1:0]  coef_q [0:2][0:TERMS-1];
    logic signed [DW-1:0]  snap_q [0:TERMS-1];

    logic                   accept;
    logic [1:0]             wrBank, rdBank;
    logic signed [AW-1:0]   mulA, mulB;
    logic signed [2*AW-1:0] mulP;
    logic signed [AW-1:0]   macRes, xNorm, vNorm, vExp, divR, scaled;
    logic signed [SW-1:0]   eNorm, xiExp;
    int                     lead;

    function automatic logic signed [AW-1:0] scaleDown(input logic signed [2*AW-1:0] p);
        logic signed [2*AW-1:0] t;
        t = (p + RND) >>> FW;
        return t[AW-1:0];
    endfunction

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign out_data  = out_q;
    assign out_err   = err_q;
    assign wrBank    = coef_op - 2'd1;
    assign rdBank    = op - 2'd1;

    // The single multiplier: MAC product at accept, Horner step in POLY, y scaling in SCALE
    always_comb begin
        mulA = AW'(x);
        mulB = AW'(y);
        if (state_q == S_POLY) begin
            mulA = acc_q;
            mulB = v_q;
        end else if (state_q == S_SCALE) begin
            mulA = acc_q;
            mulB = AW'(y_q);
        end
    end

    assign mulP   = mulA * mulB;
    assign macRes = mulP[AW-1:0] + (acc_en ? accReg_q : z);

    always_comb begin
        lead = 0;
        for (int i = 0; i < DW; i++) begin
            if (x_q[i]) lead = i;
        end
        if (lead >= FW-1) xNorm = AW'(x_q) >>> (lead - (FW-1));
        else              xNorm = AW'(x_q) <<< ((FW-1) - lead);
        vNorm = (AW'(3) <<< (FW-2)) - xNorm;
        eNorm = SW'(lead - (FW-1));
        vExp  = AW'({1'b0, x_q[FW-1:0]});
        xiExp = SW'($signed(x_q[DW-1:FW]));
    end

    // e_q carries the exponent for div/log and the integer part xi for exp2
    always_comb begin
        divR   = scaleDown(mulP);
        scaled = acc_q;
        if (op_q == OP_DIV) begin
            if (!e_q[SW-1] && e_q != '0) scaled = divR >>> e_q;
            else                         scaled = divR <<< (-e_q);
        end else if (op_q == OP_EXP) begin
            if (!e_q[SW-1]) scaled = acc_q <<< e_q;
            else            scaled = acc_q >>> (-e_q);
        end else begin
            scaled = acc_q + (AW'(e_q) <<< FW);
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        accReg_d = accReg_q;
        v_d      = v_q;
        e_d      = e_q;
        k_d      = k_q;
        out_d    = out_q;
        err_d    = err_q;
        case (state_q)
            S_NORM: begin
                acc_d = AW'(snap_q[TERMS-1]);
                k_d   = IW'(TERMS-2);
                if (op_q == OP_EXP) begin
                    v_d     = vExp;
                    e_d     = xiExp;
                    state_d = S_POLY;
                end else if (x_q[DW-1] || x_q == '0) begin
                    err_d   = 1'b1;
                    out_d   = (op_q == OP_DIV) ? MAX_V : MIN_V;
                    state_d = S_DONE;
                end else begin
                    v_d     = vNorm;
                    e_d     = eNorm;
                    state_d = S_POLY;
                end
            end
            S_POLY: begin
                acc_d = scaleDown(mulP) + AW'(snap_q[k_q]);
                if (k_q == '0) state_d = S_SCALE;
                else           k_d = k_q - IW'(1);
            end
            S_SCALE: begin
                out_d   = scaled;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: ;
        endcase
        // A new accept overrides the DONE->IDLE step so back-to-back ops chain without a bubble
        if (accept) begin
            op_d  = op;
            x_d   = x;
            y_d   = y;
            err_d = 1'b0;
            if (op == OP_MAC) begin
                out_d    = macRes;
                accReg_d = macRes;
                state_d  = S_DONE;
            end else begin
                state_d = S_NORM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_MAC;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            accReg_q <= '0;
            v_q      <= '0;
            e_q      <= '0;
            k_q      <= '0;
            out_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            accReg_q <= accReg_d;
            v_q      <= v_d;
            e_q      <= e_d;
            k_q      <= k_d;
            out_q    <= out_d;
            err_q    <= err_d;
        end
    end

    // The op works from a snapshot taken at accept, so a same-edge write is not seen by it
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 3; b++) begin
                for (int t = 0; t < TERMS; t++) coef_q[b][t] <= '0;
            end
            for (int t = 0; t < TERMS; t++) snap_q[t] <= '0;
        end else begin
            if (coef_we && state_q == S_IDLE && coef_op != OP_MAC)
                coef_q[wrBank][coef_idx] <= coef_data;
            if (accept && op != OP_MAC) begin
                for (int t = 0; t < TERMS; t++) snap_q[t] <= coef_q[rdBank][t];
            end
        end
    end

endmodule
